// File: rtl/trs_video_capture_if.sv
// Display-RAM write port of the TRS-80 video capture block.
// The RAM port always accepts, so there is no ready/valid back-pressure.
//   master : capture side, drives the strobe, address and data
//   slave  : RAM side (or any observer), receives them
// Signals
//   cap_wr_en    one-cycle write strobe
//   cap_wr_addr  {x[6:0], y[7:0]} byte address in the scan-out format
//   cap_wr_data  eight packed pixels, first sampled pixel in bit 7
interface trs_video_capture_if;
  logic        cap_wr_en;
  logic [14:0] cap_wr_addr;
  logic [7:0]  cap_wr_data;

  modport master (output cap_wr_en, cap_wr_addr, cap_wr_data);
  modport slave  (input  cap_wr_en, cap_wr_addr, cap_wr_data);
endinterface

// File: rtl/trs_video_capture.sv
// Receive side of the TRS-80 video interface. Samples the host's 1-bit video,
// HSYNC and VSYNC, recovers pixel timing with a phase accumulator restarted on
// every HSYNC trailing edge, and packs active pixels MSB-first into bytes that
// are written into the display RAM at {x,y}. Also measures frame length,
// reports lock and emits a one-cycle genlock pulse per frame.
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              0 holds the capture FSM idle (no writes)
//   TRS_VID/HSYNC/VSYNC host video and syncs, asynchronous to clk
//   cap                 display-RAM write port (master side)
//   genlock             one-cycle pulse on VSYNC leading edge while locked
//   locked              last two frames had the same nonzero line count
//   frame_lines         line count of the last complete frame
//   line_err            sticky: a sync edge cut a line short of its bytes
module trs_video_capture #(
  parameter logic [15:0] PHASE_INC = 16'h1F00,
  parameter logic [9:0]  LEFT_SKIP = 10'd64,
  parameter logic [8:0]  TOP_SKIP  = 9'd24,
  parameter logic [6:0]  ACT_BYTES = 7'd48,
  parameter logic [7:0]  ACT_LINES = 8'd192,
  parameter logic [9:0]  MAX_LINES = 10'd400,
  parameter logic        SYNC_POL  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       TRS_VID,
  input  logic                       TRS_HSYNC,
  input  logic                       TRS_VSYNC,
  trs_video_capture_if.master        cap,
  output logic                       genlock,
  output logic                       locked,
  output logic [9:0]                 frame_lines,
  output logic                       line_err
);

  typedef enum logic [2:0] {IDLE, VSYNC, VBLANK, HSKIP, CAPTURE, HWAIT, VWAIT} state_t;
  state_t state;

  logic        vid_s1, vid_s2, hs_s1, hs_s2, vs_s1, vs_s2;
  logic        hs_d, vs_d;
  logic        hs_act, vs_act, hs_lead, hs_trail, vs_lead, vs_trail;
  logic [15:0] acc, acc_sum;
  logic        sample;
  logic [9:0]  lc, lc_inc;
  logic        timeout;
  logic [9:0]  cnt;
  logic [6:0]  x;
  logic [7:0]  y;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, shreg_next;

  // Two-flop synchronizers plus the edge register. The sync flops reset to
  // the inactive sync level so releasing reset never fakes a sync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_s1 <= 1'b0;
      vid_s2 <= 1'b0;
      hs_s1  <= ~SYNC_POL;
      hs_s2  <= ~SYNC_POL;
      vs_s1  <= ~SYNC_POL;
      vs_s2  <= ~SYNC_POL;
      hs_d   <= 1'b0;
      vs_d   <= 1'b0;
    end else begin
      vid_s1 <= TRS_VID;
      vid_s2 <= vid_s1;
      hs_s1  <= TRS_HSYNC;
      hs_s2  <= hs_s1;
      vs_s1  <= TRS_VSYNC;
      vs_s2  <= vs_s1;
      hs_d   <= hs_act;
      vs_d   <= vs_act;
    end
  end

  // Syncs normalized to active-high before edge detection.
  assign hs_act   = (hs_s2 == SYNC_POL);
  assign vs_act   = (vs_s2 == SYNC_POL);
  assign hs_lead  = hs_act & ~hs_d;
  assign hs_trail = ~hs_act & hs_d;
  assign vs_lead  = vs_act & ~vs_d;
  assign vs_trail = ~vs_act & vs_d;

  // A pixel is sampled on each carry out of the accumulator.
  assign {sample, acc_sum} = {1'b0, acc} + {1'b0, PHASE_INC};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc <= 16'd0;
    else if (hs_trail) acc <= 16'd0;
    else               acc <= acc_sum;
  end

  // A VSYNC edge on the same cycle as the HSYNC edge that would hit the
  // limit takes priority, so the timeout is suppressed in that case.
  assign lc_inc  = lc + 10'd1;
  assign timeout = hs_trail && !vs_lead && (lc_inc == MAX_LINES);

  // Frame-length measurement, lock and genlock run regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lc          <= 10'd0;
      frame_lines <= 10'd0;
      locked      <= 1'b0;
      genlock     <= 1'b0;
    end else begin
      genlock <= vs_lead & locked;
      if (vs_lead) begin
        frame_lines <= lc;
        locked      <= (lc == frame_lines) && (lc != 10'd0);
        lc          <= 10'd0;
      end else if (timeout) begin
        frame_lines <= 10'd0;
        locked      <= 1'b0;
        lc          <= 10'd0;
      end else if (state == VSYNC && vs_trail) begin
        lc <= 10'd0;
      end else if (hs_trail) begin
        lc <= lc_inc;
      end
    end
  end

  assign shreg_next = {shreg[6:0], vid_s2};

  // Capture FSM. cnt counts skipped lines in VBLANK and skipped samples in
  // HSKIP; the two uses never overlap. Sync edges that cut a line short
  // drop the partial byte simply by not writing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 10'd0;
      x               <= 7'd0;
      y               <= 8'd0;
      bit_cnt         <= 3'd0;
      shreg           <= 8'd0;
      cap.cap_wr_en   <= 1'b0;
      cap.cap_wr_addr <= 15'd0;
      cap.cap_wr_data <= 8'd0;
      line_err        <= 1'b0;
    end else begin
      cap.cap_wr_en <= 1'b0;
      if (!enable || timeout) begin
        state <= IDLE;
      end else if (vs_lead && state != IDLE && state != VSYNC) begin
        if (state == CAPTURE) line_err <= 1'b1;
        state <= VSYNC;
      end else begin
        case (state)
          IDLE: if (vs_lead) state <= VSYNC;
          VSYNC: if (vs_trail) begin
            cnt   <= 10'd0;
            state <= VBLANK;
          end
          VBLANK: if (hs_trail) begin
            if (cnt == {1'b0, TOP_SKIP} - 10'd1) begin
              cnt   <= 10'd0;
              y     <= 8'd0;
              state <= HSKIP;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
          HSKIP: begin
            if (hs_lead) begin
              line_err <= 1'b1;
              state    <= HWAIT;
            end else if (sample) begin
              if (cnt == LEFT_SKIP - 10'd1) begin
                x       <= 7'd0;
                bit_cnt <= 3'd0;
                state   <= CAPTURE;
              end else begin
                cnt <= cnt + 10'd1;
              end
            end
          end
          CAPTURE: begin
            if (hs_lead) begin
              line_err <= 1'b1;
              state    <= HWAIT;
            end else if (sample) begin
              shreg   <= shreg_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                cap.cap_wr_en   <= 1'b1;
                cap.cap_wr_addr <= {x, y};
                cap.cap_wr_data <= shreg_next;
                x               <= x + 7'd1;
                if (x == ACT_BYTES - 7'd1) state <= HWAIT;
              end
            end
          end
          HWAIT: if (hs_trail) begin
            cnt <= 10'd0;
            if (y == ACT_LINES - 8'd1) begin
              state <= VWAIT;
            end else begin
              y     <= y + 8'd1;
              state <= HSKIP;
            end
          end
          VWAIT: if (vs_lead) state <= VSYNC;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trs_video_capture.sv
// Self-checking bench for trs_video_capture. A reduced geometry keeps frames
// short. The bench drives whole frames of host video; each host pixel is
// placed so the DUT's accumulator samples it mid-pixel. Expected RAM writes
// are queued when a line is driven and popped as the DUT writes them. A small
// model of line counting tracks frame_lines, locked, genlock and line_err.
module tb_trs_video_capture;

  localparam logic [15:0] P_INC   = 16'h3000;
  localparam logic [9:0]  L_SKIP  = 10'd8;
  localparam logic [8:0]  T_SKIP  = 9'd3;
  localparam logic [6:0]  A_BYTES = 7'd4;
  localparam logic [7:0]  A_LINES = 8'd6;
  localparam logic [9:0]  M_LINES = 10'd40;
  localparam int FRM_LINES   = 12;
  localparam int BODY        = 240;
  localparam int SHORT_BODY  = 150;
  localparam int ABORT_BYTES = 2;
  localparam int H_PULSE     = 8;
  localparam int V_PULSE     = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       TRS_VID, TRS_HSYNC, TRS_VSYNC;
  logic       genlock, locked, line_err;
  logic [9:0] frame_lines;

  trs_video_capture_if cap_if ();

  trs_video_capture #(
    .PHASE_INC(P_INC), .LEFT_SKIP(L_SKIP), .TOP_SKIP(T_SKIP), .ACT_BYTES(A_BYTES),
    .ACT_LINES(A_LINES), .MAX_LINES(M_LINES), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .TRS_VID(TRS_VID),
    .TRS_HSYNC(TRS_HSYNC), .TRS_VSYNC(TRS_VSYNC), .cap(cap_if),
    .genlock(genlock), .locked(locked), .frame_lines(frame_lines), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int writes_seen = 0, gen_seen = 0, gen_exp = 0;
  logic [22:0] exp_q[$];
  logic [22:0] exp_w;

  int   lc_m = 0, fl_m = 0, t_line = 0, cur_y = 0, rst_hold = 0;
  bit   lock_m = 0, cap_on = 0, err_m = 0, pat_mode = 0;
  bit   rst_req = 0, rst_done = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int x, input int y);
    if (!pat_mode) return 8'hA5;
    return 8'(x * 37 + y * 11 + 60);
  endfunction

  // Host pixel shown c cycles after the HSYNC trailing pin edge; boundaries
  // sit half a pixel away from where the DUT's n-th sample lands.
  function automatic logic pix_bit(input int c);
    int n, j;
    logic [7:0] b;
    n = int'((longint'(c) * longint'(P_INC) + 64'd32768) >> 16);
    j = n - int'(L_SKIP) - 1;
    if (j < 0 || j >= int'(A_BYTES) * 8) return 1'b0;
    b = pat(j / 8, cur_y);
    return b[7 - (j % 8)];
  endfunction

  // One clock step; also fires the pending mid-write reset.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst_n = 1'b1;
    end else if (rst_req && cap_if.cap_wr_en) begin
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", {cap_if.cap_wr_en, cap_if.cap_wr_addr, cap_if.cap_wr_data,
                  genlock, locked, frame_lines, line_err}, 64'd0);
      exp_q.delete();
      lc_m = 0; fl_m = 0; lock_m = 0; cap_on = 0; err_m = 0;
      rst_req = 0; rst_done = 1; rst_hold = 3;
    end
  endtask

  task automatic driveVsync();
    bit exp_gen;
    exp_gen = lock_m;
    if (exp_gen) gen_exp++;
    lock_m = (lc_m == fl_m) && (lc_m != 0);
    fl_m   = lc_m;
    lc_m   = 0;
    t_line = 0;
    cap_on = enable;
    TRS_VSYNC = 1'b1;
    repeat (3) tick();
    checkOutput("genlock_pulse", 64'(genlock), 64'(exp_gen));
    tick();
    checkOutput("genlock_width", 64'(genlock), 64'd0);
    repeat (V_PULSE - 4) tick();
    TRS_VSYNC = 1'b0;
    repeat (20) tick();
    checkOutput("locked", 64'(locked), 64'(lock_m));
    checkOutput("frame_lines", 64'(frame_lines), 64'(fl_m));
  endtask

  task automatic driveLine(input int body, input bit abort);
    int nb;
    TRS_HSYNC = 1'b1;
    repeat (H_PULSE) tick();
    TRS_HSYNC = 1'b0;
    t_line++;
    lc_m++;
    if (lc_m == int'(M_LINES)) begin
      lc_m = 0; fl_m = 0; lock_m = 0; cap_on = 0;
    end
    cur_y = t_line - int'(T_SKIP);
    if (cap_on && cur_y >= 0 && cur_y < int'(A_LINES)) begin
      nb = abort ? ABORT_BYTES : int'(A_BYTES);
      for (int x = 0; x < nb; x++) exp_q.push_back({7'(x), 8'(cur_y), pat(x, cur_y)});
      if (abort) err_m = 1'b1;
    end
    for (int c = 0; c < body; c++) begin
      TRS_VID = pix_bit(c);
      tick();
    end
  endtask

  task automatic applyStimulus(input int nlines, input int abort_t);
    driveVsync();
    for (int t = 1; t <= nlines; t++)
      driveLine((t == abort_t) ? SHORT_BODY : BODY, t == abort_t);
  endtask

  // Write scoreboard.
  always @(negedge clk) begin
    if (rst_n && cap_if.cap_wr_en) begin
      writes_seen++;
      checkOutput("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        checkOutput("wr_addr", 64'(cap_if.cap_wr_addr), 64'(exp_w[22:8]));
        checkOutput("wr_data", 64'(cap_if.cap_wr_data), 64'(exp_w[7:0]));
      end
    end
    if (genlock) gen_seen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    TRS_VID = 1'b0; TRS_HSYNC = 1'b0; TRS_VSYNC = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {cap_if.cap_wr_en, cap_if.cap_wr_addr, cap_if.cap_wr_data,
                genlock, locked, frame_lines, line_err}, 64'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    $display("[TB] constant 8'hA5 frames, lock and genlock");
    pat_mode = 0;
    for (int f = 0; f < 4; f++) begin
      writes_seen = 0;
      applyStimulus(FRM_LINES, -1);
      checkOutput("writes_per_frame", 64'(writes_seen), 64'(int'(A_BYTES) * int'(A_LINES)));
    end
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] line cut short by HSYNC");
    pat_mode = 1;
    writes_seen = 0;
    applyStimulus(FRM_LINES, int'(T_SKIP) + 2);
    checkOutput("abort_writes", 64'(writes_seen),
                64'(int'(A_BYTES) * int'(A_LINES) - int'(A_BYTES) + ABORT_BYTES));
    checkOutput("line_err_set", 64'(line_err), 64'(err_m));

    $display("[TB] enable low for a whole frame");
    enable = 1'b0;
    writes_seen = 0;
    applyStimulus(FRM_LINES, -1);
    checkOutput("disabled_writes", 64'(writes_seen), 64'd0);
    checkOutput("line_err_hold", 64'(line_err), 64'(err_m));
    enable = 1'b1;

    $display("[TB] missing VSYNC timeout");
    applyStimulus(int'(M_LINES) + 5, -1);
    checkOutput("timeout_locked", 64'(locked), 64'(lock_m));
    checkOutput("timeout_frame_lines", 64'(frame_lines), 64'(fl_m));

    $display("[TB] reset during a write");
    rst_req = 1;
    applyStimulus(FRM_LINES, -1);
    checkOutput("reset_hit", 64'(rst_done), 64'd1);
    writes_seen = 0;
    applyStimulus(FRM_LINES, -1);
    checkOutput("writes_after_reset", 64'(writes_seen), 64'(int'(A_BYTES) * int'(A_LINES)));

    repeat (10) tick();
    checkOutput("final_queue", 64'(exp_q.size()), 64'd0);
    checkOutput("genlock_count", 64'(gen_seen), 64'(gen_exp));
    checkOutput("line_err_final", 64'(line_err), 64'(err_m));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
